// File: rtl/timer_pkg.sv
// Shared state encoding, BCD limits and preset clamp for the 60-second timer sequencer.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSE   = 2'd2,
        EXPIRED = 2'd3
    } timer_state_e;

    localparam logic [3:0] MAX_TENS = 4'd5;
    localparam logic [3:0] MAX_ONES = 4'd9;

    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] ones;
    } bcd2_t;

    // Any digit outside the 00..59 range forces the full 59 limit.
    function automatic bcd2_t clamp_preset(input logic [3:0] tens, input logic [3:0] ones);
        bcd2_t v;
        if (tens > MAX_TENS || ones > MAX_ONES) begin
            v.tens = MAX_TENS;
            v.ones = MAX_ONES;
        end else begin
            v.tens = tens;
            v.ones = ones;
        end
        return v;
    endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Modulo-DIV tick prescaler: counts 0..DIV-1 while run is high, holds otherwise, zeroed by clr.
module timer_prescaler #(
    parameter int DIV = 10
) (
    input  logic CLOCK_50,
    input  logic Reset,
    input  logic clr,
    input  logic run,
    output logic done
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (run) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (Reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = run && !clr && (cnt_q == LAST);

endmodule

// File: rtl/timer_sequencer.sv
// Start/stop/clear sequencer for the 60 s BCD timer: count enable, load strobe, terminal detect.
// Define TIMER_ALARM_EN to build the blinking alarm output in EXPIRED; otherwise alarm is 0.
//
//   state   | meaning
//   IDLE    | stopped, prescaler cleared, waiting for start
//   RUN     | prescaler counting, tick_en each period until terminal count
//   PAUSE   | prescaler frozen, partial period kept
//   EXPIRED | terminal count reached, waiting for start or clear
module timer_sequencer
    import timer_pkg::*;
#(
    parameter int CLK_HZ  = 50_000_000,
    parameter int TICK_HZ = 1
`ifdef TIMER_ALARM_EN
    ,
    parameter int BLINK_TICKS = 2
`endif
) (
    input  logic       CLOCK_50,
    input  logic       Reset,
    input  logic       start_stop,
    input  logic       clear,
    input  logic       dir_down,
    input  logic [3:0] preset_tens,
    input  logic [3:0] preset_ones,
    input  logic [3:0] cnt_tens,
    input  logic [3:0] cnt_ones,
    output logic       tick_en,
    output logic       cnt_dir,
    output logic       cnt_load,
    output logic [3:0] load_tens,
    output logic [3:0] load_ones,
    output logic       running,
    output logic       expired,
    output logic       alarm
);

    localparam int DIV = CLK_HZ / TICK_HZ;

    logic [1:0]   ss_sync_q;
    logic         ss_prev_q;
    logic         ss_edge_q;
    logic [1:0]   clr_sync_q;
    logic         clr_prev_q;
    logic         clr_edge_q;

    timer_state_e state_q;
    logic         tick_en_q;
    logic         cnt_load_q;
    logic         cnt_dir_q;
    logic [3:0]   load_tens_q;
    logic [3:0]   load_ones_q;
    logic         running_q;
    logic         expired_q;

    bcd2_t        preset_c;
    bcd2_t        load_val;
    logic         load_dir;
    logic         at_term;
    logic         pre_clr;
    logic         pre_run;
    logic         pre_done;

    always_ff @(posedge CLOCK_50) begin
        if (Reset) begin
            ss_sync_q  <= '0;
            ss_prev_q  <= 1'b0;
            ss_edge_q  <= 1'b0;
            clr_sync_q <= '0;
            clr_prev_q <= 1'b0;
            clr_edge_q <= 1'b0;
        end else begin
            ss_sync_q  <= {ss_sync_q[0], start_stop};
            ss_prev_q  <= ss_sync_q[1];
            ss_edge_q  <= ss_sync_q[1] & ~ss_prev_q;
            clr_sync_q <= {clr_sync_q[0], clear};
            clr_prev_q <= clr_sync_q[1];
            clr_edge_q <= clr_sync_q[1] & ~clr_prev_q;
        end
    end

    // dir_down is only honoured while stopped; afterwards the latched direction rules.
    assign preset_c = clamp_preset(preset_tens, preset_ones);
    assign load_dir = (state_q == IDLE) ? dir_down : cnt_dir_q;
    assign load_val = load_dir ? preset_c : '0;
    assign at_term  = cnt_dir_q ? (cnt_tens == 4'd0 && cnt_ones == 4'd0)
                                : (cnt_tens == preset_c.tens && cnt_ones == preset_c.ones);

`ifdef TIMER_ALARM_EN
    assign pre_run = (state_q == RUN) || (state_q == EXPIRED);
    assign pre_clr = (state_q == IDLE);
`else
    assign pre_run = (state_q == RUN);
    assign pre_clr = (state_q == IDLE) || (state_q == EXPIRED);
`endif

    timer_prescaler #(
        .DIV(DIV)
    ) u_prescaler (
        .CLOCK_50(CLOCK_50),
        .Reset   (Reset),
        .clr     (pre_clr),
        .run     (pre_run),
        .done    (pre_done)
    );

    always_ff @(posedge CLOCK_50) begin
        if (Reset) begin
            state_q     <= IDLE;
            tick_en_q   <= 1'b0;
            cnt_load_q  <= 1'b0;
            cnt_dir_q   <= 1'b0;
            load_tens_q <= 4'd0;
            load_ones_q <= 4'd0;
            running_q   <= 1'b0;
            expired_q   <= 1'b0;
        end else begin
            tick_en_q  <= 1'b0;
            cnt_load_q <= 1'b0;
            if (clr_edge_q) begin
                state_q     <= IDLE;
                running_q   <= 1'b0;
                expired_q   <= 1'b0;
                cnt_load_q  <= 1'b1;
                load_tens_q <= load_val.tens;
                load_ones_q <= load_val.ones;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (ss_edge_q) begin
                            state_q     <= RUN;
                            running_q   <= 1'b1;
                            cnt_dir_q   <= dir_down;
                            cnt_load_q  <= 1'b1;
                            load_tens_q <= load_val.tens;
                            load_ones_q <= load_val.ones;
                        end
                    end
                    RUN: begin
                        if (ss_edge_q) begin
                            state_q   <= PAUSE;
                            running_q <= 1'b0;
                        end else if (pre_done) begin
                            if (at_term) begin
                                state_q   <= EXPIRED;
                                running_q <= 1'b0;
                                expired_q <= 1'b1;
                            end else begin
                                tick_en_q <= 1'b1;
                            end
                        end
                    end
                    PAUSE: begin
                        if (ss_edge_q) begin
                            state_q   <= RUN;
                            running_q <= 1'b1;
                        end
                    end
                    EXPIRED: begin
                        if (ss_edge_q) begin
                            state_q   <= IDLE;
                            expired_q <= 1'b0;
                        end
                    end
                    default: begin
                        state_q   <= IDLE;
                        running_q <= 1'b0;
                        expired_q <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef TIMER_ALARM_EN
    localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);

    logic          enter_exp;
    logic          leave_exp;
    logic [BW-1:0] blink_cnt_q;
    logic          alarm_q;

    assign enter_exp = (state_q == RUN) && !clr_edge_q && !ss_edge_q && pre_done && at_term;
    assign leave_exp = (state_q == EXPIRED) && (clr_edge_q || ss_edge_q);

    // The prescaler wraps on the entry edge, so blink periods line up with whole ticks.
    always_ff @(posedge CLOCK_50) begin
        if (Reset) begin
            blink_cnt_q <= '0;
            alarm_q     <= 1'b0;
        end else if (enter_exp) begin
            blink_cnt_q <= '0;
            alarm_q     <= 1'b1;
        end else if (state_q != EXPIRED || leave_exp) begin
            blink_cnt_q <= '0;
            alarm_q     <= 1'b0;
        end else if (pre_done) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_q <= '0;
                alarm_q     <= ~alarm_q;
            end else begin
                blink_cnt_q <= blink_cnt_q + 1'b1;
            end
        end
    end

    assign alarm = alarm_q;
`else
    assign alarm = 1'b0;
`endif

    assign tick_en   = tick_en_q;
    assign cnt_load  = cnt_load_q;
    assign cnt_dir   = cnt_dir_q;
    assign load_tens = load_tens_q;
    assign load_ones = load_ones_q;
    assign running   = running_q;
    assign expired   = expired_q;

endmodule

// File: tb/tb_timer_sequencer.sv
// Bench for timer_sequencer: directed corner sequences, a preset clamp table and randomized
// switch traffic checked every cycle against a behavioural model plus a BCD datapath model.
module tb_timer_sequencer;

    localparam int CLK_HZ  = 10;
    localparam int TICK_HZ = 1;
    localparam int DIV     = CLK_HZ / TICK_HZ;
    localparam int BLINK   = 2;
`ifdef TIMER_ALARM_EN
    localparam bit ALARM_EN = 1'b1;
`else
    localparam bit ALARM_EN = 1'b0;
`endif

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_EXP   = 3;

    logic       CLOCK_50 = 1'b0;
    logic       Reset = 1'b1;
    logic       start_stop = 1'b0;
    logic       clear = 1'b0;
    logic       dir_down = 1'b0;
    logic [3:0] preset_tens = 4'd0;
    logic [3:0] preset_ones = 4'd0;
    logic [3:0] cnt_tens = 4'd0;
    logic [3:0] cnt_ones = 4'd0;
    logic       tick_en;
    logic       cnt_dir;
    logic       cnt_load;
    logic [3:0] load_tens;
    logic [3:0] load_ones;
    logic       running;
    logic       expired;
    logic       alarm;

    timer_sequencer #(
        .CLK_HZ (CLK_HZ),
        .TICK_HZ(TICK_HZ)
    ) dut (
        .CLOCK_50   (CLOCK_50),
        .Reset      (Reset),
        .start_stop (start_stop),
        .clear      (clear),
        .dir_down   (dir_down),
        .preset_tens(preset_tens),
        .preset_ones(preset_ones),
        .cnt_tens   (cnt_tens),
        .cnt_ones   (cnt_ones),
        .tick_en    (tick_en),
        .cnt_dir    (cnt_dir),
        .cnt_load   (cnt_load),
        .load_tens  (load_tens),
        .load_ones  (load_ones),
        .running    (running),
        .expired    (expired),
        .alarm      (alarm)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int dp       = 0;

    // behavioural model state
    int m_mode = M_IDLE;
    int m_rc   = 0;
    int m_exp  = 0;
    int m_lv   = 0;
    bit m_dir  = 1'b0;
    bit m_tick = 1'b0;
    bit m_load = 1'b0;
    bit hs[4] = '{default: 1'b0};
    bit hc[4] = '{default: 1'b0};

    typedef struct {
        logic       dir;
        logic [3:0] pt;
        logic [3:0] po;
        logic [7:0] exp_ld;
    } clamp_vec_t;

    clamp_vec_t vecs[8];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int clamp_val(input int t, input int o);
        return (t > 5 || o > 9) ? 59 : t * 10 + o;
    endfunction

    function automatic int dut_vec();
        logic [13:0] v;
        v = {tick_en, cnt_load, running, expired, alarm, cnt_dir, load_tens, load_ones};
        return {18'd0, v};
    endfunction

    function automatic int model_vec();
        logic [13:0] v;
        logic        al;
        al = ALARM_EN && (m_mode == M_EXP) && (((m_exp / (BLINK * DIV)) % 2) == 0);
        v = {m_tick, m_load, (m_mode == M_RUN), (m_mode == M_EXP), al, m_dir,
             4'(m_lv / 10), 4'(m_lv % 10)};
        return {18'd0, v};
    endfunction

    // Advances the model by one clock edge using the inputs the DUT sampled at that edge.
    task automatic model_edge(input int dp_old);
        bit s_cmd, c_cmd, done;
        int pv, lv;
        if (Reset) begin
            m_mode = M_IDLE; m_rc = 0; m_exp = 0; m_lv = 0;
            m_dir = 0; m_tick = 0; m_load = 0;
            hs = '{default: 1'b0};
            hc = '{default: 1'b0};
            return;
        end
        s_cmd = hs[2] && !hs[3];
        c_cmd = hc[2] && !hc[3];
        for (int k = 3; k > 0; k--) begin
            hs[k] = hs[k-1];
            hc[k] = hc[k-1];
        end
        hs[0] = start_stop;
        hc[0] = clear;
        pv = clamp_val(int'(preset_tens), int'(preset_ones));
        lv = (((m_mode == M_IDLE) ? dir_down : m_dir) != 0) ? pv : 0;
        done = 0;
        if (m_mode == M_RUN) begin
            m_rc++;
            done = (m_rc % DIV) == 0;
        end else if (m_mode == M_IDLE) begin
            m_rc = 0;
        end else if (m_mode == M_EXP) begin
            m_exp++;
        end
        m_tick = 0;
        m_load = 0;
        if (c_cmd) begin
            m_mode = M_IDLE; m_load = 1; m_lv = lv;
        end else begin
            case (m_mode)
                M_IDLE: if (s_cmd) begin
                    m_mode = M_RUN; m_dir = dir_down; m_load = 1; m_lv = lv;
                end
                M_RUN: if (s_cmd) begin
                    m_mode = M_PAUSE;
                end else if (done) begin
                    if ((m_dir && dp_old == 0) || (!m_dir && dp_old == pv)) begin
                        m_mode = M_EXP; m_exp = 0;
                    end else begin
                        m_tick = 1;
                    end
                end
                M_PAUSE: if (s_cmd) m_mode = M_RUN;
                default: if (s_cmd) m_mode = M_IDLE;
            endcase
        end
    endtask

    task automatic step();
        logic       p_tick, p_load, p_dir;
        logic [3:0] p_lt, p_lo;
        int         dp_old;
        p_tick = tick_en; p_load = cnt_load; p_dir = cnt_dir;
        p_lt = load_tens; p_lo = load_ones;
        dp_old = dp;
        @(posedge CLOCK_50);
        model_edge(dp_old);
        if (Reset) dp = 0;
        else if (p_load) dp = int'(p_lt) * 10 + int'(p_lo);
        else if (p_tick) dp = p_dir ? ((dp == 0) ? 59 : dp - 1) : ((dp == 59) ? 0 : dp + 1);
        cyc++;
        #1;
        cnt_tens = 4'(dp / 10);
        cnt_ones = 4'(dp % 10);
        check("model_outputs", dut_vec(), model_vec());
    endtask

    task automatic run_until(input int sel, input int budget, output int n);
        n = -1;
        for (int i = 1; i <= budget; i++) begin
            step();
            if ((sel == 0 && tick_en) || (sel == 1 && cnt_load) || (sel == 2 && expired)) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic press_start();
        start_stop = 1'b1;
        step();
        start_stop = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, ticks, loads, runs;

        vecs[0] = '{1'b1, 4'd0, 4'd3,  8'h03};
        vecs[1] = '{1'b1, 4'd7, 4'd12, 8'h59};
        vecs[2] = '{1'b1, 4'd5, 4'd9,  8'h59};
        vecs[3] = '{1'b1, 4'd6, 4'd0,  8'h59};
        vecs[4] = '{1'b1, 4'd2, 4'd10, 8'h59};
        vecs[5] = '{1'b0, 4'd4, 4'd4,  8'h00};
        vecs[6] = '{1'b1, 4'd0, 4'd0,  8'h00};
        vecs[7] = '{1'b1, 4'd4, 4'd7,  8'h47};

        step();
        step();
        check("reset_outputs", dut_vec(), 0);
        Reset = 1'b0;
        step();

        // count down from 03
        dir_down = 1'b1; preset_tens = 4'd0; preset_ones = 4'd3;
        press_start();
        run_until(1, 10, n);
        check("down_load_latency", n, 3);
        check("down_load_value", {load_tens, load_ones}, 8'h03);
        check("down_running", running, 1);
        step();
        check("load_one_cycle", cnt_load, 0);
        run_until(0, 30, n);
        check("first_tick", n, DIV - 1);
        run_until(0, 30, n);
        check("tick_period_2", n, DIV);
        run_until(0, 30, n);
        check("tick_period_3", n, DIV);
        run_until(2, 30, n);
        check("down_expire", n, DIV);
        check("expire_no_tick", tick_en, 0);
        check("down_final_count", dp, 0);
        ticks = 0;
        repeat (30) begin step(); ticks += int'(tick_en); end
        check("no_tick_after_expire", ticks, 0);
        check("expired_held", expired, 1);
        press_start();
        repeat (3) step();
        check("expired_to_idle", {running, expired}, 0);

        // count up to 02
        dir_down = 1'b0; preset_tens = 4'd0; preset_ones = 4'd2;
        press_start();
        run_until(1, 10, n);
        check("up_load_latency", n, 3);
        check("up_load_value", {load_tens, load_ones}, 8'h00);
        check("up_dir", cnt_dir, 0);
        step();
        run_until(0, 30, n);
        check("up_first_tick", n, DIV - 1);
        run_until(0, 30, n);
        check("up_tick_2", n, DIV);
        run_until(2, 30, n);
        check("up_expire", n, DIV);
        check("up_final_count", dp, 2);
        check("alarm_enter", alarm, ALARM_EN);
        repeat (19) step();
        check("alarm_hold", alarm, ALARM_EN);
        step();
        check("alarm_toggle", alarm, 0);
        repeat (20) step();
        check("alarm_retoggle", alarm, ALARM_EN);
        clear = 1'b1; step(); clear = 1'b0;
        repeat (3) step();
        check("clear_from_expired", {running, expired, alarm}, 0);
        check("clear_expired_load", cnt_load, 1);
        check("clear_expired_value", {load_tens, load_ones}, 8'h00);

        // pause after 15 cycles of RUN, resume after 50
        dir_down = 1'b1; preset_tens = 4'd5; preset_ones = 4'd9;
        press_start();
        run_until(1, 10, n);
        check("pause_load_latency", n, 3);
        repeat (11) step();
        press_start();
        repeat (3) step();
        check("paused", running, 0);
        ticks = 0; loads = 0;
        repeat (50) begin step(); ticks += int'(tick_en); loads += int'(cnt_load); end
        check("pause_no_tick", ticks, 0);
        press_start();
        repeat (3) begin step(); loads += int'(cnt_load); end
        check("resumed", running, 1);
        check("resume_no_load", loads, 0);
        run_until(0, 20, n);
        check("resume_tick", n, 5);

        // simultaneous clear and start during RUN
        repeat (3) step();
        start_stop = 1'b1; clear = 1'b1;
        step();
        start_stop = 1'b0; clear = 1'b0;
        loads = 0;
        repeat (3) begin step(); loads += int'(cnt_load); end
        check("clr_start_idle", running, 0);
        repeat (5) begin step(); loads += int'(cnt_load); end
        check("clr_start_one_load", loads, 1);
        check("clr_start_value", {load_tens, load_ones}, 8'h59);

        // reset in the middle of RUN
        press_start();
        run_until(1, 10, n);
        check("rst_run_load_latency", n, 3);
        repeat (13) step();
        Reset = 1'b1;
        step();
        check("reset_mid_run", dut_vec(), 0);
        Reset = 1'b0;
        ticks = 0; runs = 0;
        repeat (25) begin step(); ticks += int'(tick_en); runs += int'(running); end
        check("reset_no_tick", ticks, 0);
        check("reset_stays_idle", runs, 0);

        // preset clamp table, exercised through a clear in IDLE
        for (int i = 0; i < 8; i++) begin
            dir_down = vecs[i].dir;
            preset_tens = vecs[i].pt;
            preset_ones = vecs[i].po;
            clear = 1'b1; step(); clear = 1'b0;
            run_until(1, 10, n);
            check($sformatf("clamp_latency[%0d]", i), n, 3);
            check($sformatf("clamp_value[%0d]", i), {load_tens, load_ones}, vecs[i].exp_ld);
        end

        // randomized switch traffic
        repeat (4000) begin
            if ($urandom_range(0, 99) == 0) start_stop = ~start_stop;
            if ($urandom_range(0, 399) == 0) clear = ~clear;
            if ($urandom_range(0, 199) == 0) dir_down = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 199) == 0) begin
                preset_tens = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(6, 15))
                                                          : 4'($urandom_range(0, 2));
                preset_ones = 4'($urandom_range(0, 11));
            end
            Reset = ($urandom_range(0, 2999) == 0);
            step();
        end
        Reset = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
